// File: rtl/toy_bpu_rob_ctrl.sv
// Fetch ROB control: allocates entries to icache fetches, decodes acks/bp2,
// and drains the head in order via read (valid) or bypass (killed).
package toy_pack;
  localparam int TOY_FETCH_DATA_WIDTH = 32;
endpackage

module toy_bpu_rob_ctrl #(
  parameter int ROB_DEPTH        = 8,
  parameter int FETCH_DATA_WIDTH = toy_pack::TOY_FETCH_DATA_WIDTH,
  localparam int IDX_W           = $clog2(ROB_DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  fetch_req_vld,
  output logic                                  fetch_req_rdy,
  output logic [IDX_W-1:0]                      fetch_req_idx,
  output logic [ROB_DEPTH-1:0]                  icache_prealloc,
  input  logic                                  icache_ack_vld,
  input  logic [IDX_W-1:0]                      icache_ack_idx,
  output logic [ROB_DEPTH-1:0]                  entry_ack_vld,
  input  logic                                  bp2_vld,
  input  logic                                  bp2_flush,
  input  logic [IDX_W-1:0]                      bp2_idx,
  output logic [ROB_DEPTH-1:0]                  entry_bp2_vld,
  output logic [ROB_DEPTH-1:0]                  entry_bp2_flush,
  input  logic                                  fe_ctrl_flush,
  input  logic [ROB_DEPTH-1:0]                  rob_entry_wait,
  input  logic [ROB_DEPTH-1:0]                  rob_entry_vld,
  input  logic [ROB_DEPTH-1:0]                  rob_entry_invalid,
  input  logic [ROB_DEPTH*FETCH_DATA_WIDTH-1:0] filter_pld,
  output logic [ROB_DEPTH-1:0]                  filter_rden,
  output logic [ROB_DEPTH-1:0]                  filter_bypass,
  output logic                                  out_vld,
  input  logic                                  out_rdy,
  output logic [FETCH_DATA_WIDTH-1:0]           out_pld
);

  localparam logic [ROB_DEPTH-1:0] ONE     = ROB_DEPTH'(1);
  localparam logic [IDX_W:0]       PTR_ONE = (IDX_W+1)'(1);

  logic [IDX_W:0]   wr_ptr;
  logic [IDX_W:0]   rd_ptr;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             full;
  logic             empty;
  logic             alloc;
  logic             head_ok;
  logic             bypass_go;
  logic             rden_go;
  logic             pop;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];

  assign full  = (wr_idx == rd_idx) &
                 (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  assign empty = (wr_ptr == rd_ptr);

  assign fetch_req_rdy = ~full & ~fe_ctrl_flush &
                         ~rob_entry_wait[wr_idx];
  assign fetch_req_idx = wr_idx;
  assign alloc         = fetch_req_vld & fetch_req_rdy;

  // killed entries must not be released while their ack is outstanding
  assign head_ok   = ~empty & ~fe_ctrl_flush;
  assign bypass_go = head_ok & rob_entry_invalid[rd_idx] &
                     ~rob_entry_wait[rd_idx];
  assign out_vld   = head_ok & ~rob_entry_invalid[rd_idx] &
                     rob_entry_vld[rd_idx];
  assign rden_go   = out_vld & out_rdy;
  assign pop       = bypass_go | rden_go;
  assign out_pld   = filter_pld[rd_idx*FETCH_DATA_WIDTH +: FETCH_DATA_WIDTH];

  always_comb begin
    icache_prealloc = '0;
    entry_ack_vld   = '0;
    entry_bp2_vld   = '0;
    entry_bp2_flush = '0;
    filter_rden     = '0;
    filter_bypass   = '0;
    if (alloc)          icache_prealloc = ONE << wr_idx;
    if (icache_ack_vld) entry_ack_vld   = ONE << icache_ack_idx;
    if (bp2_vld)        entry_bp2_vld   = ONE << bp2_idx;
    if (bp2_flush)      entry_bp2_flush = ONE << bp2_idx;
    if (rden_go)        filter_rden     = ONE << rd_idx;
    if (bypass_go)      filter_bypass   = ONE << rd_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (fe_ctrl_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (alloc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  a_bp2_excl: assert property (
    @(posedge clk) disable iff (!rst_n) !(bp2_vld && bp2_flush)
  );

endmodule

// File: tb/tb_toy_bpu_rob_ctrl.sv
// Bench for toy_bpu_rob_ctrl: scoreboard queues for allocations and
// drains, popped by a negedge monitor; direct checks for decode/flush.
module tb_toy_bpu_rob_ctrl;

  localparam int D = 8;
  localparam int W = 32;

  typedef struct {
    logic [2:0]   idx;
    logic [D-1:0] pre;
  } alc_t;

  typedef struct {
    logic [D-1:0] rden;
    logic [D-1:0] byp;
    logic [W-1:0] pld;
  } drn_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           fetch_req_vld;
  logic           fetch_req_rdy;
  logic [2:0]     fetch_req_idx;
  logic [D-1:0]   icache_prealloc;
  logic           icache_ack_vld;
  logic [2:0]     icache_ack_idx;
  logic [D-1:0]   entry_ack_vld;
  logic           bp2_vld;
  logic           bp2_flush;
  logic [2:0]     bp2_idx;
  logic [D-1:0]   entry_bp2_vld;
  logic [D-1:0]   entry_bp2_flush;
  logic           fe_ctrl_flush;
  logic [D-1:0]   rob_entry_wait;
  logic [D-1:0]   rob_entry_vld;
  logic [D-1:0]   rob_entry_invalid;
  logic [D*W-1:0] filter_pld;
  logic [D-1:0]   filter_rden;
  logic [D-1:0]   filter_bypass;
  logic           out_vld;
  logic           out_rdy;
  logic [W-1:0]   out_pld;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  alc_t alloc_q[$];
  drn_t drain_q[$];
  logic [W-1:0] pld [D];

  always #5 clk = ~clk;

  toy_bpu_rob_ctrl #(.ROB_DEPTH(D), .FETCH_DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req_vld(fetch_req_vld), .fetch_req_rdy(fetch_req_rdy),
    .fetch_req_idx(fetch_req_idx), .icache_prealloc(icache_prealloc),
    .icache_ack_vld(icache_ack_vld), .icache_ack_idx(icache_ack_idx),
    .entry_ack_vld(entry_ack_vld), .bp2_vld(bp2_vld),
    .bp2_flush(bp2_flush), .bp2_idx(bp2_idx),
    .entry_bp2_vld(entry_bp2_vld), .entry_bp2_flush(entry_bp2_flush),
    .fe_ctrl_flush(fe_ctrl_flush), .rob_entry_wait(rob_entry_wait),
    .rob_entry_vld(rob_entry_vld), .rob_entry_invalid(rob_entry_invalid),
    .filter_pld(filter_pld), .filter_rden(filter_rden),
    .filter_bypass(filter_bypass), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_pld(out_pld)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [D-1:0] oh(int i);
    logic [D-1:0] v;
    v = '0;
    v[i%D] = 1'b1;
    return v;
  endfunction

  task automatic push_a(int i);
    alc_t a;
    a.idx = 3'(i % D);
    a.pre = oh(i);
    alloc_q.push_back(a);
  endtask

  task automatic push_r(int i);
    drn_t d;
    d.rden = oh(i);
    d.byp  = '0;
    d.pld  = pld[i%D];
    drain_q.push_back(d);
  endtask

  task automatic push_b(int i);
    drn_t d;
    d.rden = '0;
    d.byp  = oh(i);
    d.pld  = '0;
    drain_q.push_back(d);
  endtask

  // monitor: every handshake or release strobe must match the next expectation
  always @(negedge clk) begin
    if (mon_en && rst_n === 1'b1) begin
      if (fetch_req_vld && fetch_req_rdy) begin
        if (alloc_q.size() == 0) begin
          chk("unexpected_alloc", {61'd0, fetch_req_idx}, 64'hFFFF);
        end else begin
          alc_t a;
          a = alloc_q.pop_front();
          chk("alloc_idx", {61'd0, fetch_req_idx}, {61'd0, a.idx});
          chk("prealloc", {56'd0, icache_prealloc}, {56'd0, a.pre});
        end
      end else begin
        chk("prealloc_idle", {56'd0, icache_prealloc}, 64'd0);
      end
      if ((filter_rden | filter_bypass) != '0) begin
        if (drain_q.size() == 0) begin
          chk("unexpected_drain", {48'd0, filter_rden, filter_bypass}, 64'd0);
        end else begin
          drn_t d;
          d = drain_q.pop_front();
          chk("rden", {56'd0, filter_rden}, {56'd0, d.rden});
          chk("bypass", {56'd0, filter_bypass}, {56'd0, d.byp});
          if (d.rden != '0) begin
            chk("out_pld", {32'd0, out_pld}, {32'd0, d.pld});
            chk("rd_out_vld", {63'd0, out_vld}, 64'd1);
          end else begin
            chk("byp_out_vld", {63'd0, out_vld}, 64'd0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < D; i++) begin
      pld[i] = 32'hA5000000 + 32'(i * 32'h01010101);
      filter_pld[i*W +: W] = pld[i];
    end
    rst_n = 1'b0;
    fetch_req_vld = 0; icache_ack_vld = 0; icache_ack_idx = 0;
    bp2_vld = 0; bp2_flush = 0; bp2_idx = 0; fe_ctrl_flush = 0;
    rob_entry_wait = 0; rob_entry_vld = 0; rob_entry_invalid = 0;
    out_rdy = 0;
    repeat (3) step();
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_rdy", {63'd0, fetch_req_rdy}, 64'd1);
    chk("rst_idx", {61'd0, fetch_req_idx}, 64'd0);
    chk("rst_out_vld", {63'd0, out_vld}, 64'd0);
    chk("rst_strobes", {48'd0, filter_rden, filter_bypass}, 64'd0);
    step();

    // fill all eight entries back to back
    fetch_req_vld = 1;
    for (int i = 0; i < D; i++) begin
      push_a(i);
      step();
    end
    // ninth request held while full; head 0 stalls on out_rdy
    push_a(0);
    rob_entry_vld = oh(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_rdy", {63'd0, fetch_req_rdy}, 64'd0);
      chk("stall_out_vld", {63'd0, out_vld}, 64'd1);
      chk("stall_pld", {32'd0, out_pld}, {32'd0, pld[0]});
      chk("stall_rden", {56'd0, filter_rden}, 64'd0);
      step();
    end
    push_r(0);
    out_rdy = 1;
    step();
    rob_entry_vld = 0;
    step();
    fetch_req_vld = 0;

    rob_entry_vld = oh(1);
    push_r(1);
    step();
    rob_entry_vld = 0;

    // killed head waits for its ack before bypass; invalid beats vld
    rob_entry_invalid = oh(2);
    rob_entry_wait = oh(2);
    rob_entry_vld = oh(2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("inv_wait_byp", {56'd0, filter_bypass}, 64'd0);
      chk("inv_out_vld", {63'd0, out_vld}, 64'd0);
      step();
    end
    rob_entry_wait = 0;
    push_b(2);
    step();
    rob_entry_invalid = 0;
    rob_entry_vld = 0;

    rob_entry_vld = 8'hF9;
    for (int k = 3; k <= 8; k++) push_r(k);
    repeat (6) step();
    rob_entry_vld = 0;

    // five in flight, then flush with entry 0 ack outstanding
    fetch_req_vld = 1;
    for (int i = 1; i <= 5; i++) begin
      push_a(i);
      step();
    end
    rob_entry_wait = oh(0);
    fe_ctrl_flush = 1;
    rob_entry_vld = oh(1);
    icache_ack_vld = 1;
    icache_ack_idx = 3'd2;
    @(negedge clk);
    chk("flush_rdy", {63'd0, fetch_req_rdy}, 64'd0);
    chk("flush_out_vld", {63'd0, out_vld}, 64'd0);
    chk("flush_rden", {56'd0, filter_rden}, 64'd0);
    chk("flush_ack", {56'd0, entry_ack_vld}, 64'h04);
    step();
    fe_ctrl_flush = 0;
    rob_entry_vld = 0;
    icache_ack_vld = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_flush_idx", {61'd0, fetch_req_idx}, 64'd0);
      chk("post_flush_rdy", {63'd0, fetch_req_rdy}, 64'd0);
      step();
    end
    push_a(0);
    rob_entry_wait = 0;
    step();
    fetch_req_vld = 0;
    rob_entry_vld = oh(0);
    push_r(0);
    step();
    rob_entry_vld = 0;
    fe_ctrl_flush = 1;
    step();
    fe_ctrl_flush = 0;

    // continuous alloc+drain across the wrap
    for (int c = 0; c <= 12; c++) begin
      fetch_req_vld = (c < 12);
      if (c < 12) push_a(c);
      rob_entry_vld = (c > 0) ? oh(c - 1) : '0;
      if (c > 0) push_r(c - 1);
      step();
    end
    fetch_req_vld = 0;
    rob_entry_vld = 0;
    chk("wrap_alloc_left", 64'(alloc_q.size()), 64'd0);
    chk("wrap_drain_left", 64'(drain_q.size()), 64'd0);

    // concurrent ack and bp2 decode
    icache_ack_vld = 1; icache_ack_idx = 3'd5;
    bp2_flush = 1; bp2_idx = 3'd5;
    @(negedge clk);
    chk("ack5", {56'd0, entry_ack_vld}, 64'h20);
    chk("bp2_flush5", {56'd0, entry_bp2_flush}, 64'h20);
    chk("bp2_vld_off", {56'd0, entry_bp2_vld}, 64'h00);
    step();
    icache_ack_vld = 0;
    bp2_flush = 0; bp2_vld = 1; bp2_idx = 3'd3;
    @(negedge clk);
    chk("bp2_vld3", {56'd0, entry_bp2_vld}, 64'h08);
    chk("bp2_flush_off", {56'd0, entry_bp2_flush}, 64'h00);
    chk("ack_off", {56'd0, entry_ack_vld}, 64'h00);
    step();
    bp2_vld = 0;

    // asynchronous reset mid-operation
    fetch_req_vld = 1;
    push_a(4);
    push_a(5);
    repeat (2) step();
    fetch_req_vld = 0;
    #2;
    rst_n = 0;
    #1;
    chk("arst_idx", {61'd0, fetch_req_idx}, 64'd0);
    chk("arst_rdy", {63'd0, fetch_req_rdy}, 64'd1);
    chk("arst_out_vld", {63'd0, out_vld}, 64'd0);
    step();
    rst_n = 1;
    step();
    chk("end_alloc_left", 64'(alloc_q.size()), 64'd0);
    chk("end_drain_left", 64'(drain_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/toy_bpu_rob_ctrl.md
Name: toy_bpu_rob_ctrl

Overview:
- Control side of the BPU fetch reorder buffer: allocates entries to outgoing icache fetches and decodes icache acks and bp2 results into per-entry one-hot strobes.
- Drains entries strictly in order to the fetch filter: valid entries are read out, flushed-invalid entries are released by bypass.
- Sits between fe_ctrl/icache and an array of ROB_DEPTH per-entry ROB instances; it is the allocator/reader counterpart of the entry storage.

Parameters:
ROB_DEPTH, 8, number of entries; power of two, >=2
IDX_W, $clog2(ROB_DEPTH), entry index width (derived, not overridden)
FETCH_DATA_WIDTH, toy_pack value, fetch payload width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
fetch_req_vld  in  1  fe_ctrl requests a new fetch slot
fetch_req_rdy  out  1  slot available
fetch_req_idx  out  IDX_W  allocated entry index (= wr_ptr)
icache_prealloc  out  ROB_DEPTH  one-hot prealloc strobe to entries
icache_ack_vld  in  1  icache response valid
icache_ack_idx  in  IDX_W  entry targeted by response
entry_ack_vld  out  ROB_DEPTH  one-hot ack strobe to entries (payload is broadcast externally)
bp2_vld  in  1  bp2 confirms fetch
bp2_flush  in  1  bp2 kills fetch
bp2_idx  in  IDX_W  entry targeted by bp2
entry_bp2_vld  out  ROB_DEPTH  one-hot
entry_bp2_flush  out  ROB_DEPTH  one-hot
fe_ctrl_flush  in  1  global flush
rob_entry_wait  in  ROB_DEPTH  per-entry awaiting icache ack
rob_entry_vld  in  ROB_DEPTH  per-entry data ready
rob_entry_invalid  in  ROB_DEPTH  per-entry killed, awaiting release
filter_pld  in  ROB_DEPTH*FETCH_DATA_WIDTH  per-entry payloads; entry i at bits [i*W +: W]
filter_rden  out  ROB_DEPTH  one-hot read/release
filter_bypass  out  ROB_DEPTH  one-hot bypass release
out_vld  out  1  head payload valid to filter
out_rdy  in  1  filter accepts
out_pld  out  FETCH_DATA_WIDTH  head payload

Behaviour:
- State:
  - wr_ptr and rd_ptr: IDX_W bits each plus a wrap bit.
  - full = (ptr bits equal) and (wrap bits differ). empty = (ptr bits equal) and (wrap bits equal).
  - Reset: both pointers 0, wrap bits 0.
- Allocation:
  - fetch_req_rdy = ~full & ~fe_ctrl_flush & ~rob_entry_wait[wr_ptr].
  - The rob_entry_wait term stops reuse of an entry whose pre-flush icache ack is still outstanding.
  - On handshake, icache_prealloc[wr_ptr]=1 in the same cycle (combinational) and wr_ptr increments next edge, wrapping ROB_DEPTH-1 -> 0 with the wrap bit toggled.
- Decode:
  - entry_ack_vld = icache_ack_vld ? onehot(icache_ack_idx) : 0. Purely combinational, no ptr check. Passes through during flush.
  - entry_bp2_vld and entry_bp2_flush are decoded the same way from bp2_idx.
  - bp2_vld and bp2_flush asserted together is illegal (assertion).
- Head drain (combinational from head h = rd_ptr), at most one pop per cycle, only when ~empty & ~fe_ctrl_flush:
  - rob_entry_invalid[h] & ~rob_entry_wait[h]: filter_bypass[h]=1, out_vld=0, pop.
  - rob_entry_vld[h]: out_vld=1, out_pld=filter_pld[h]; if out_rdy then filter_rden[h]=1, pop.
  - Otherwise: out_vld=0, no strobes.
  - invalid takes priority over vld.
- Pop: rd_ptr increments next edge, with the same wrap rule as wr_ptr.
- Simultaneous alloc and pop: both pointers advance; occupancy unchanged. Alloc is legal when full only if a pop occurs in the same cycle? No — rdy uses the registered full flag, so there is no same-cycle forwarding.
- fe_ctrl_flush: next edge wr_ptr=rd_ptr=0 and wrap bits 0. During the flush cycle, rdy=0, out_vld=0, and filter_rden/filter_bypass=0.
- out_pld is don't-care when out_vld=0, but must be driven from filter_pld[h] (no X).
- Reset mid-operation: pointers clear asynchronously; all outputs go to the empty-state values immediately.
- Reset/empty output values: fetch_req_rdy=1 (if ~rob_entry_wait[0]), fetch_req_idx=0, out_vld=0; icache_prealloc, filter_rden and filter_bypass all 0.

Test Plan:
- Reset, 8 back-to-back fetch_req_vld -> idx 0..7 with prealloc one-hot 0x01..0x80, then rdy=0 (full). The 9th request is held until one pop.
- Entry 0 vld=1 with out_rdy held low 3 cycles -> out_vld=1 stable with out_pld=filter_pld[0]. Raise out_rdy -> filter_rden=0x01 for one cycle, rd_ptr=1.
- Head 2 invalid=1, wait=1 -> no bypass. Drop wait -> filter_bypass=0x04 for one cycle, out_vld=0, head moves to 3.
- Wrap: alloc and drain 12 entries continuously -> fetch_req_idx sequence 0..7,0..3, no stalls with out_rdy=1.
- Flush with 5 in flight and rob_entry_wait[0]=1 -> next cycle pointers 0 and fetch_req_rdy=0 until wait[0] drops, then idx 0 is issued.
- icache_ack_idx=5 with bp2_flush at idx=5 in the same cycle -> entry_ack_vld=0x20 and entry_bp2_flush=0x20 concurrently.
